// File: rtl/rc_pkg.sv
// Shared definitions for the BLESS route-computation stage: direction indices,
// default address field widths and the saturating age increment.
package rc_pkg;

    localparam int DIR_RPOS  = 0;
    localparam int DIR_RNEG  = 1;
    localparam int DIR_CPOS  = 2;
    localparam int DIR_CNEG  = 3;
    localparam int DIR_EJECT = 4;
    localparam int NDIR      = 5;

    localparam int ROWW_DEF  = 2;
    localparam int COLW_DEF  = 2;

    // Ages up to 32 bits wide; the caller truncates the result back to its own width.
    function automatic logic [31:0] age_sat_inc(input logic [31:0] age, input int width);
        logic [31:0] lim;
        lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (age >= lim) ? lim : age + 32'd1;
    endfunction

endpackage

// File: rtl/rc_dir_calc.sv
// Combinational productive-direction mask for one channel.
// Build with RC_TORUS_EN for wrap-around (shortest-way) routing; default is plain mesh.
module rc_dir_calc
    import rc_pkg::*;
#(
    parameter int ROWW = ROWW_DEF,
    parameter int COLW = COLW_DEF,
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic [ROWW+COLW-1:0] i_dst,
    input  logic [ROWW+COLW-1:0] i_node,
    output logic [NDIR-1:0]      o_desired
);

    logic [ROWW-1:0] w_dr;
    logic [ROWW-1:0] w_ir;
    logic [COLW-1:0] w_dc;
    logic [COLW-1:0] w_ic;

    assign w_dr = i_dst[COLW +: ROWW];
    assign w_ir = i_node[COLW +: ROWW];
    assign w_dc = i_dst[0 +: COLW];
    assign w_ic = i_node[0 +: COLW];

`ifdef RC_TORUS_EN
    int w_rdelta;
    int w_cdelta;

    // Modular distance: add DIM first when d<i so non-power-of-two sizes work.
    always_comb begin
        o_desired = '0;
        w_rdelta  = (w_dr >= w_ir) ? int'(w_dr) - int'(w_ir) : int'(w_dr) + ROWS - int'(w_ir);
        w_cdelta  = (w_dc >= w_ic) ? int'(w_dc) - int'(w_ic) : int'(w_dc) + COLS - int'(w_ic);
        if (i_dst == i_node) begin
            o_desired[DIR_EJECT] = 1'b1;
        end else begin
            if (w_rdelta != 0) begin
                if (w_rdelta <= ROWS / 2) o_desired[DIR_RPOS] = 1'b1;
                else                      o_desired[DIR_RNEG] = 1'b1;
            end
            if (w_cdelta != 0) begin
                if (w_cdelta <= COLS / 2) o_desired[DIR_CPOS] = 1'b1;
                else                      o_desired[DIR_CNEG] = 1'b1;
            end
        end
    end
`else
    logic [31:0] w_unused_dims;
    assign w_unused_dims = 32'(ROWS) ^ 32'(COLS);

    always_comb begin
        o_desired            = '0;
        o_desired[DIR_RPOS]  = (w_dr > w_ir);
        o_desired[DIR_RNEG]  = (w_dr < w_ir);
        o_desired[DIR_CPOS]  = (w_dc > w_ic);
        o_desired[DIR_CNEG]  = (w_dc < w_ic);
        o_desired[DIR_EJECT] = (i_dst == i_node);
    end
`endif

endmodule

// File: rtl/rc_pipe.sv
// Registered route-computation stage: per-channel direction mask, saturating age,
// and a saturating ejection counter with global stall. RC_TORUS_EN selects torus routing.
module rc_pipe
    import rc_pkg::*;
#(
    parameter int ROWW = ROWW_DEF,
    parameter int COLW = COLW_DEF,
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int NCH  = 4,
    parameter int AGEW = 8,
    parameter int CNTW = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ROWW+COLW-1:0]       node_id,
    input  logic                       stall,
    input  logic [NCH-1:0]             in_valid,
    input  logic [NCH*(ROWW+COLW)-1:0] in_dst,
    input  logic [NCH*AGEW-1:0]        in_age,
    output logic [NCH-1:0]             out_valid,
    output logic [NCH*NDIR-1:0]        out_desired,
    output logic [NCH*AGEW-1:0]        out_age,
    output logic [CNTW-1:0]            eject_cnt,
    input  logic                       clr_cnt
);

    localparam int AW = ROWW + COLW;
    localparam int PW = $clog2(NCH + 1);
    localparam int SW = CNTW + PW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NCH*NDIR-1:0] w_desired;
    logic [NCH*NDIR-1:0] w_next_desired;
    logic [NCH*AGEW-1:0] w_next_age;
    logic [PW-1:0]       w_pop;
    logic [SW-1:0]       w_sum;
    logic [CNTW-1:0]     w_cnt_next;

    logic [NCH-1:0]      r_valid;
    logic [NCH*NDIR-1:0] r_desired;
    logic [NCH*AGEW-1:0] r_age;
    logic [CNTW-1:0]     r_cnt;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        rc_dir_calc #(
            .ROWW (ROWW),
            .COLW (COLW),
            .ROWS (ROWS),
            .COLS (COLS)
        ) u_dir (
            .i_dst     (in_dst[gi*AW +: AW]),
            .i_node    (node_id),
            .o_desired (w_desired[gi*NDIR +: NDIR])
        );
    end

    // Invalid channels carry an all-zero mask and age so stale data never leaks downstream.
    always_comb begin
        w_next_desired = '0;
        w_next_age     = '0;
        w_pop          = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i]) begin
                w_next_desired[i*NDIR +: NDIR] = w_desired[i*NDIR +: NDIR];
                w_next_age[i*AGEW +: AGEW]     = AGEW'(age_sat_inc(32'(in_age[i*AGEW +: AGEW]), AGEW));
                if (w_desired[i*NDIR + DIR_EJECT]) w_pop = w_pop + PW'(1);
            end
        end
    end

    assign w_sum      = SW'(r_cnt) + SW'(w_pop);
    assign w_cnt_next = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNTW-1:0];

    // Clear wins over stall so software can zero the counter while the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_desired <= '0;
            r_age     <= '0;
            r_cnt     <= '0;
        end else begin
            if (!stall) begin
                r_valid   <= in_valid;
                r_desired <= w_next_desired;
                r_age     <= w_next_age;
            end
            if (clr_cnt)     r_cnt <= '0;
            else if (!stall) r_cnt <= w_cnt_next;
        end
    end

    assign out_valid   = r_valid;
    assign out_desired = r_desired;
    assign out_age     = r_age;
    assign eject_cnt   = r_cnt;

endmodule
